// File: rtl/axi_lite_wr_responder_pkg.sv
// Shared types for the AXI4-Lite write responder.
//   resp_t      : B channel response codes
//   wr_state_t  : write FSM states
//   word_index(): byte address -> word index (drops the byte-lane bits)
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    RESP  = 2'd2
  } wr_state_t;

  // lsb is the number of byte-lane address bits (2 for 32-bit, 3 for 64-bit data).
  function automatic logic [31:0] word_index(input logic [63:0] byte_addr,
                                             input int unsigned lsb);
    return 32'(byte_addr >> lsb);
  endfunction

endpackage

// File: rtl/axi_lite_wr_responder_if.sv
// AXI4-Lite write-channel bundle (AW, W, B).
//   master : drives AWADDR/AWVALID, WDATA/WSTRB/WVALID, BREADY
//   slave  : drives AWREADY, WREADY, BRESP/BVALID
interface axi_lite_wr_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    input  AWREADY, WREADY, BRESP, BVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    output AWREADY, WREADY, BRESP, BVALID
  );

endinterface

// File: rtl/axi_lite_wr_responder_hs_buf.sv
// One-entry VALID/READY capture buffer.
//   clk, srst : clock, synchronous active-high reset
//   in_valid  : upstream VALID
//   in_ready  : upstream READY (buffer empty), purely from state
//   in_data   : payload captured on in_valid && in_ready
//   clr       : empties the buffer (payload is kept)
//   full/data : buffer status and captured payload
module axi_hs_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clr,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    // clr is only raised while full, so it never races a capture.
    if (clr) begin
      full_d = 1'b0;
    end else if (in_valid && !full_q) begin
      full_d = 1'b1;
      data_d = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign in_ready = !full_q;
  assign full     = full_q;
  assign data     = data_q;

endmodule

// File: rtl/axi_lite_wr_responder.sv
// AXI4-Lite subordinate write responder: buffers one AW and one W beat,
// performs a single strobed write through a simple memory port, returns B.
//   ACLK, ARESET : clock, synchronous active-high reset
//   s_axi        : AW/W/B channels (slave side)
//   mem_we       : one-cycle write strobe
//   mem_addr     : word index
//   mem_wdata    : captured WDATA
//   mem_wstrb    : captured WSTRB
//   mem_busy     : memory cannot take a write this cycle
// DATA_WIDTH must be 32 or 64.
module axi_lite_wr_responder
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  axi_lite_wr_if.slave                s_axi,
  output logic                        mem_we,
  output logic [$clog2(NUM_REGS)-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]       mem_wdata,
  output logic [DATA_WIDTH/8-1:0]     mem_wstrb,
  input  logic                        mem_busy
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(NUM_REGS);

  logic                         aw_full, w_full, buf_clr;
  logic [ADDR_WIDTH-1:0]        aw_addr;
  logic [DATA_WIDTH+STRB_W-1:0] w_buf;
  logic [DATA_WIDTH-1:0]        w_data;
  logic [STRB_W-1:0]            w_strb;
  logic                         in_range;

  wr_state_t state_q, state_d;
  resp_t     bresp_q, bresp_d;

  axi_hs_buf #(.WIDTH(ADDR_WIDTH)) u_aw_buf (
    .clk      (ACLK),
    .srst     (ARESET),
    .in_valid (s_axi.AWVALID),
    .in_ready (s_axi.AWREADY),
    .in_data  (s_axi.AWADDR),
    .clr      (buf_clr),
    .full     (aw_full),
    .data     (aw_addr)
  );

  axi_hs_buf #(.WIDTH(DATA_WIDTH + STRB_W)) u_w_buf (
    .clk      (ACLK),
    .srst     (ARESET),
    .in_valid (s_axi.WVALID),
    .in_ready (s_axi.WREADY),
    .in_data  ({s_axi.WDATA, s_axi.WSTRB}),
    .clr      (buf_clr),
    .full     (w_full),
    .data     (w_buf)
  );

  assign w_data = w_buf[STRB_W +: DATA_WIDTH];
  assign w_strb = w_buf[STRB_W-1:0];

  // Full-width compare so addresses beyond the mem_addr range are caught.
  assign in_range = word_index(64'(aw_addr), ADDR_LSB) < NUM_REGS;

  // The memory port follows the buffers directly; only mem_we qualifies it.
  assign mem_addr  = aw_addr[ADDR_LSB +: IDX_W];
  assign mem_wdata = w_data;
  assign mem_wstrb = w_strb;

  always_comb begin
    state_d = state_q;
    bresp_d = bresp_q;
    mem_we  = 1'b0;
    buf_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (aw_full && w_full) state_d = WRITE;
      end
      WRITE: begin
        // Out-of-range and empty-strobe writes never touch memory, so
        // they do not wait on mem_busy.
        if (!in_range) begin
          bresp_d = SLVERR;
          state_d = RESP;
        end else if (w_strb == '0) begin
          bresp_d = OKAY;
          state_d = RESP;
        end else if (!mem_busy) begin
          mem_we  = 1'b1;
          bresp_d = OKAY;
          state_d = RESP;
        end
      end
      RESP: begin
        if (s_axi.BREADY) begin
          buf_clr = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= IDLE;
      bresp_q <= OKAY;
    end else begin
      state_q <= state_d;
      bresp_q <= bresp_d;
    end
  end

  assign s_axi.BVALID = (state_q == RESP);
  assign s_axi.BRESP  = bresp_q;

endmodule

// File: tb/tb_axi_lite_wr_responder.sv
// Self-checking bench for axi_lite_wr_responder (32-bit data, 16 words).
// Inputs change 1 ns after the rising edge; outputs are sampled at the
// falling edge. Expected outcomes come from the write rules: word index,
// range check, strobe check and the fixed latency from capture to B.
module tb_axi_lite_wr_responder;

  logic        clk = 1'b0;
  logic        areset;
  logic        mem_we;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_busy;

  always #5 clk = ~clk;

  axi_lite_wr_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  axi_lite_wr_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(16)) dut (
    .ACLK      (clk),
    .ARESET    (areset),
    .s_axi     (bus),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_busy  (mem_busy)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_mem [16];
  logic [31:0] act_mem [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
    return r;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.AWADDR  = '0;
    bus.AWVALID = 1'b0;
    bus.WDATA   = '0;
    bus.WSTRB   = '0;
    bus.WVALID  = 1'b0;
    bus.BREADY  = 1'b0;
    mem_busy    = 1'b0;
  endtask

  // Called at posedge+1 right after a reset edge.
  task automatic check_reset(input string tag);
    #4;
    chk({tag, "_awready"}, 64'(bus.AWREADY), 64'd1);
    chk({tag, "_wready"},  64'(bus.WREADY),  64'd1);
    chk({tag, "_bvalid"},  64'(bus.BVALID),  64'd0);
    chk({tag, "_bresp"},   64'(bus.BRESP),   64'd0);
    chk({tag, "_mem_we"},  64'(mem_we),      64'd0);
    chk({tag, "_addr"},    64'(mem_addr),    64'd0);
    chk({tag, "_wdata"},   64'(mem_wdata),   64'd0);
    chk({tag, "_wstrb"},   64'(mem_wstrb),   64'd0);
  endtask

  // One complete write transaction. Delays count cycles from the start;
  // busy_n cycles of mem_busy start with the first cycle the write could
  // happen; BREADY rises after bready_dly cycles of BVALID. aw_hold keeps a
  // second AW on the bus after the first is accepted.
  task automatic run_txn(input string tag, input logic [7:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int aw_dly, input int w_dly,
                         input int busy_n, input int bready_dly, input bit aw_hold);
    bit aw_done = 0, w_done = 0, b_done = 0, exp_wr, aw_v, w_v;
    int c = -1, exp_we = -1, exp_bv = -1, we_seen = 0, bv_cnt = 0;
    int idx;
    logic [1:0] exp_resp;
    idx      = int'(addr) / 4;
    exp_wr   = (idx < 16) && (strb != 4'h0);
    exp_resp = (idx < 16) ? 2'b00 : 2'b10;
    for (int t = 0; t < 200 && !b_done; t++) begin
      aw_v = (!aw_done && t >= aw_dly) || (aw_done && aw_hold);
      w_v  = !w_done && t >= w_dly;
      bus.AWVALID = aw_v;
      bus.AWADDR  = aw_done ? 8'h3C : addr;
      bus.WVALID  = w_v;
      bus.WDATA   = data;
      bus.WSTRB   = strb;
      mem_busy    = (c >= 0) && (t > c + 1) && (t <= c + 1 + busy_n);
      bus.BREADY  = (bv_cnt >= bready_dly);
      #4;
      chk({tag, "_awready"}, 64'(bus.AWREADY), aw_done ? 64'd0 : 64'd1);
      chk({tag, "_wready"},  64'(bus.WREADY),  w_done  ? 64'd0 : 64'd1);
      if (mem_we) begin
        we_seen++;
        chk({tag, "_we_cycle"}, 64'(t), 64'(exp_we));
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(idx));
        chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(data));
        chk({tag, "_mem_wstrb"}, 64'(mem_wstrb), 64'(strb));
        act_mem[mem_addr] = merge(act_mem[mem_addr], mem_wdata, mem_wstrb);
      end
      if (bus.BVALID) begin
        if (bv_cnt == 0) chk({tag, "_bvalid_cycle"}, 64'(t), 64'(exp_bv));
        chk({tag, "_bresp"}, 64'(bus.BRESP), 64'(exp_resp));
        bv_cnt++;
        if (bus.BREADY) b_done = 1;
      end
      if (aw_v && !aw_done && bus.AWREADY) aw_done = 1;
      if (w_v && !w_done && bus.WREADY) w_done = 1;
      if (aw_done && w_done && c < 0) begin
        c      = t;
        exp_we = exp_wr ? c + 2 + busy_n : -1;
        exp_bv = exp_wr ? c + 3 + busy_n : c + 3;
      end
      next_cycle();
    end
    chk({tag, "_b_done"}, 64'(b_done), 64'd1);
    chk({tag, "_we_count"}, 64'(we_seen), exp_wr ? 64'd1 : 64'd0);
    idle_inputs();
    #4;
    chk({tag, "_post_awready"}, 64'(bus.AWREADY), 64'd1);
    chk({tag, "_post_wready"},  64'(bus.WREADY),  64'd1);
    chk({tag, "_post_bvalid"},  64'(bus.BVALID),  64'd0);
    next_cycle();
    if (exp_wr) exp_mem[idx] = merge(exp_mem[idx], data, strb);
    $display("txn %s addr=%02h data=%08h strb=%h resp=%0d write=%0d", tag, addr, data, strb,
             exp_resp, exp_wr);
  endtask

  initial begin
    logic [7:0]  r_addr;
    logic [31:0] r_data;
    logic [3:0]  r_strb;
    int          r_busy;
    for (int i = 0; i < 16; i++) begin
      exp_mem[i] = '0;
      act_mem[i] = '0;
    end
    areset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    next_cycle();
    areset = 1'b0;
    next_cycle();

    run_txn("t1_same_cycle", 8'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0);
    run_txn("t2_w_first",    8'h04, 32'h12345678, 4'hF, 3, 0, 0, 0, 0);
    run_txn("t3_busy5",      8'h14, 32'hA5A55A5A, 4'h5, 0, 1, 5, 0, 0);
    run_txn("t4_out_range",  8'h40, 32'h0BADF00D, 4'hF, 1, 0, 3, 1, 0);
    run_txn("t5_bready_low", 8'h20, 32'h13572468, 4'hC, 0, 2, 0, 10, 1);
    run_txn("strb_zero",     8'h24, 32'hFFFFFFFF, 4'h0, 0, 0, 0, 0, 0);

    // Reset in the middle of a stalled write: no B, then a clean transaction.
    bus.AWADDR  = 8'h0C;
    bus.AWVALID = 1'b1;
    bus.WDATA   = 32'hCAFEF00D;
    bus.WSTRB   = 4'hF;
    bus.WVALID  = 1'b1;
    mem_busy    = 1'b1;
    #4;
    chk("t6_accept", 64'(bus.AWREADY & bus.WREADY), 64'd1);
    next_cycle();
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #4;
      chk("t6_stall_we", 64'(mem_we), 64'd0);
      chk("t6_stall_bvalid", 64'(bus.BVALID), 64'd0);
      next_cycle();
    end
    areset = 1'b1;
    next_cycle();
    areset = 1'b0;
    check_reset("t6_reset");
    next_cycle();
    mem_busy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #4;
      chk("t6_no_b", 64'(bus.BVALID), 64'd0);
      chk("t6_no_we", 64'(mem_we), 64'd0);
      next_cycle();
    end
    run_txn("t6_after", 8'h0C, 32'h600DF00D, 4'hF, 0, 0, 0, 0, 0);

    for (int n = 0; n < 30; n++) begin
      r_addr = 8'($urandom_range(0, 8'h4F));
      r_data = $urandom;
      r_strb = 4'($urandom_range(0, 15));
      r_busy = (r_strb == 4'h0) ? 0 : $urandom_range(0, 3);
      run_txn($sformatf("rnd%0d", n), r_addr, r_data, r_strb, $urandom_range(0, 3),
              $urandom_range(0, 3), r_busy, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 16; i++) chk($sformatf("mem%0d", i), 64'(act_mem[i]), 64'(exp_mem[i]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
